// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode and funct encodings shared by decode and branch resolution
package cpu_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FUNCT_JR = 6'h08;
endpackage

// File: rtl/branch_target_calc.sv
// branch_target_calc: combinational taken decision and redirect target for beq/bne/j/jal/jr
module branch_target_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc_4_i,
  input  logic [31:0] instruction_i,
  input  logic        alu_zero_i,
  input  logic [31:0] rs_data_i,
  output logic        taken_o,
  output logic [31:0] target_o
);
  logic [5:0] op;
  logic       is_j;
  logic       is_jr;
  always_comb begin
    op       = instruction_i[31:26];
    is_j     = (op == OP_J) || (op == OP_JAL);
    is_jr    = (op == OP_RTYPE) && (instruction_i[5:0] == FUNCT_JR);
    taken_o  = ((op == OP_BEQ) && alu_zero_i) || ((op == OP_BNE) && !alu_zero_i) || is_j || is_jr;
    target_o = is_jr ? rs_data_i :
               is_j  ? {pc_4_i[31:28], instruction_i[25:0], 2'b00} :
                       pc_4_i + {{14{instruction_i[15]}}, instruction_i[15:0], 2'b00};
  end
endmodule

// File: rtl/mem_branch_unit.sv
// mem_branch_unit: EX/MEM capture, branch/jump redirect with wrong-path squash, saturating debug counters
module mem_branch_unit
  import cpu_pkg::*;
#(
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     ex_valid,
  input  logic [31:0]              ex_pc_4,
  input  logic [31:0]              ex_instruction,
  input  logic                     ex_aluZero,
  input  logic [31:0]              ex_rsData,
  output logic                     mem_valid,
  output logic [31:0]              mem_pc_4,
  output logic [31:0]              mem_instruction,
  output logic                     mem_shouldBranch,
  output logic [31:0]              mem_branchPc,
  output logic                     flush_if_id,
  output logic                     flush_id_ex,
  output logic [COUNTER_WIDTH-1:0] takenCount,
  output logic [COUNTER_WIDTH-1:0] squashCount
);
  logic                     valid_q;
  logic [31:0]              pc_4_q;
  logic [31:0]              instr_q;
  logic                     zero_q;
  logic [31:0]              rs_q;
  logic                     redirected_q;
  logic [COUNTER_WIDTH-1:0] taken_cnt_q, taken_cnt_d;
  logic [COUNTER_WIDTH-1:0] squash_cnt_q, squash_cnt_d;
  logic                     taken;
  logic [31:0]              target;
  logic                     should_branch;

  branch_target_calc u_calc (
    .pc_4_i        (pc_4_q),
    .instruction_i (instr_q),
    .alu_zero_i    (zero_q),
    .rs_data_i     (rs_q),
    .taken_o       (taken),
    .target_o      (target)
  );

  // redirected_q suppresses a second pulse while a taken instruction is held by stall
  always_comb begin
    should_branch = valid_q && taken && !redirected_q;
    taken_cnt_d   = taken_cnt_q + COUNTER_WIDTH'(should_branch && !(&taken_cnt_q));
    squash_cnt_d  = squash_cnt_q + COUNTER_WIDTH'(!stall && ex_valid && should_branch && !(&squash_cnt_q));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q      <= 1'b0;
      pc_4_q       <= '0;
      instr_q      <= '0;
      zero_q       <= 1'b0;
      rs_q         <= '0;
      redirected_q <= 1'b0;
      taken_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      taken_cnt_q  <= taken_cnt_d;
      squash_cnt_q <= squash_cnt_d;
      if (!stall) begin
        valid_q      <= ex_valid && !should_branch;
        pc_4_q       <= ex_pc_4;
        instr_q      <= ex_instruction;
        zero_q       <= ex_aluZero;
        rs_q         <= ex_rsData;
        redirected_q <= 1'b0;
      end else if (should_branch) begin
        redirected_q <= 1'b1;
      end
    end
  end

  assign mem_valid        = valid_q;
  assign mem_pc_4         = pc_4_q;
  assign mem_instruction  = instr_q;
  assign mem_shouldBranch = should_branch;
  assign mem_branchPc     = taken ? target : 32'h0;
  assign flush_if_id      = should_branch;
  assign flush_id_ex      = should_branch;
  assign takenCount       = taken_cnt_q;
  assign squashCount      = squash_cnt_q;
endmodule
